// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// FSM state encoding, command codes, error codes and a frame-header check.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_LEN,
    S_PAY,
    S_CHK
  } state_t;

  localparam logic [7:0] CMD_WRITE_REG = 8'h01;
  localparam logic [7:0] CMD_PIXELS    = 8'h02;

  localparam logic [1:0] ERR_CHK = 2'd0;
  localparam logic [1:0] ERR_CMD = 2'd1;
  localparam logic [1:0] ERR_OVF = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  function automatic logic cmd_ok(
    input logic [7:0] cmd,
    input logic [7:0] len
  );
    return (cmd == CMD_WRITE_REG && len == 8'd2) ||
           (cmd == CMD_PIXELS && len != 8'd0);
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Byte-in / register-write / pixel-stream bundle of the command sequencer.
// slave: the sequencer; master: the surrounding logic (receiver + display).
interface uart_cmd_sequencer_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_Reg_Wr;
  logic [7:0] o_Reg_Addr;
  logic [7:0] o_Reg_Data;
  logic       o_Pix_Valid;
  logic [7:0] o_Pix_Byte;
  logic       i_Pix_Ready;
  logic       o_Frame_Done;
  logic       o_Frame_Err;
  logic [1:0] o_Err_Code;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_Pix_Ready,
    output o_Reg_Wr, o_Reg_Addr, o_Reg_Data,
    output o_Pix_Valid, o_Pix_Byte,
    output o_Frame_Done, o_Frame_Err, o_Err_Code
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_Pix_Ready,
    input  o_Reg_Wr, o_Reg_Addr, o_Reg_Data,
    input  o_Pix_Valid, o_Pix_Byte,
    input  o_Frame_Done, o_Frame_Err, o_Err_Code
  );
endinterface

// File: rtl/uart_cmd_fifo.sv
// Show-ahead byte FIFO, DEPTH x 8, count-based full/empty.
// Ports: clk, rst_n, push/push_data, pop, full, valid, head.
module uart_cmd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       valid,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  // a pop frees the slot this edge, so a full FIFO can still take a push
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Frame hunter / checksum checker feeding register writes and a pixel FIFO.
// Ports: i_Clock, i_Reset_n, bus (slave). Option: UART_CMD_TIMEOUT_EN.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1200
) (
  input logic               i_Clock,
  input logic               i_Reset_n,
  uart_cmd_sequencer_if.slave bus
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CLKS < 1) begin : g_bad_param
    $error("uart_cmd_sequencer: illegal parameter value");
  end

  state_t     state;
  logic [7:0] cmd;
  logic [7:0] acc;
  logic [7:0] cnt;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic       bad;
  logic       ovf;
  logic       fifo_full;
  logic       pix_push;
  logic       drop;
  logic       tmo;

  // payload of a well-formed PIXELS frame goes straight into the FIFO
  assign pix_push = bus.i_RX_DV && state == S_PAY &&
                    !bad && cmd == CMD_PIXELS;
  assign drop     = pix_push && fifo_full && !bus.i_Pix_Ready;

  uart_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_Clock),
    .rst_n    (i_Reset_n),
    .push     (pix_push),
    .push_data(bus.i_RX_Byte),
    .pop      (bus.i_Pix_Ready),
    .full     (fifo_full),
    .valid    (bus.o_Pix_Valid),
    .head     (bus.o_Pix_Byte)
  );

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] idle;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      idle <= '0;
    end else if (bus.i_RX_DV || state == S_HUNT) begin
      idle <= '0;
    end else if (!tmo) begin
      idle <= idle + 1'b1;
    end
  end

  assign tmo = !bus.i_RX_DV && state != S_HUNT &&
               idle == TW'(TIMEOUT_CLKS);
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state            <= S_HUNT;
      cmd              <= '0;
      acc              <= '0;
      cnt              <= '0;
      addr_q           <= '0;
      data_q           <= '0;
      bad              <= 1'b0;
      ovf              <= 1'b0;
      bus.o_Reg_Wr     <= 1'b0;
      bus.o_Reg_Addr   <= '0;
      bus.o_Reg_Data   <= '0;
      bus.o_Frame_Done <= 1'b0;
      bus.o_Frame_Err  <= 1'b0;
      bus.o_Err_Code   <= '0;
    end else begin
      bus.o_Reg_Wr     <= 1'b0;
      bus.o_Frame_Done <= 1'b0;
      bus.o_Frame_Err  <= 1'b0;
      if (tmo) begin
        state           <= S_HUNT;
        bus.o_Frame_Err <= 1'b1;
        bus.o_Err_Code  <= ERR_TMO;
      end else if (bus.i_RX_DV) begin
        unique case (state)
          S_HUNT: begin
            if (bus.i_RX_Byte == SYNC_BYTE) state <= S_CMD;
          end
          S_CMD: begin
            cmd   <= bus.i_RX_Byte;
            acc   <= bus.i_RX_Byte;
            ovf   <= 1'b0;
            state <= S_LEN;
          end
          S_LEN: begin
            acc   <= acc ^ bus.i_RX_Byte;
            cnt   <= bus.i_RX_Byte;
            bad   <= !cmd_ok(cmd, bus.i_RX_Byte);
            state <= (bus.i_RX_Byte != 8'd0) ? S_PAY : S_CHK;
            if (!cmd_ok(cmd, bus.i_RX_Byte)) begin
              bus.o_Frame_Err <= 1'b1;
              bus.o_Err_Code  <= ERR_CMD;
            end
          end
          S_PAY: begin
            acc <= acc ^ bus.i_RX_Byte;
            cnt <= cnt - 1'b1;
            if (!bad && cmd == CMD_WRITE_REG) begin
              if (cnt == 8'd2) addr_q <= bus.i_RX_Byte;
              else             data_q <= bus.i_RX_Byte;
            end
            // only the first drop of a frame is reported
            if (drop && !ovf) begin
              ovf             <= 1'b1;
              bus.o_Frame_Err <= 1'b1;
              bus.o_Err_Code  <= ERR_OVF;
            end
            if (cnt == 8'd1) state <= S_CHK;
          end
          S_CHK: begin
            state <= S_HUNT;
            if (!bad) begin
              if (bus.i_RX_Byte == acc) begin
                bus.o_Frame_Done <= 1'b1;
                if (cmd == CMD_WRITE_REG) begin
                  bus.o_Reg_Wr   <= 1'b1;
                  bus.o_Reg_Addr <= addr_q;
                  bus.o_Reg_Data <= data_q;
                end
              end else begin
                bus.o_Frame_Err <= 1'b1;
                bus.o_Err_Code  <= ERR_CHK;
              end
            end
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
